pea_invoke: RTL and testbench

- Firing engine of the Polynomial Evaluation Accelerator actor. It sits directly downstream of the PEA enable check.
- The scheduler asserts invoke only when the enable block reports enable=1 for the current mode_out.
- One firing executes one mode: GET_COMMAND pops a command, COMP pops data and stores or evaluates polynomials, OUTPUT writes results and status.
- mode_out feeds the enable block's mode input.

---
 rtl/pea_pkg.sv | 45 ++++
 rtl/pea_horner_step.sv | 26 ++
 rtl/pea_invoke.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_pea_invoke.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pea_pkg.sv
// Shared definitions for the Polynomial Evaluation Accelerator firing engine.
package pea_pkg;

    localparam int unsigned WORD_SIZE   = 16;
    localparam int unsigned RESULT_SIZE = 32;
    localparam int unsigned NUM_SLOTS   = 8;
    localparam int unsigned MAX_TERMS   = 32;
    localparam int unsigned INSTR_W     = 8;
    localparam int unsigned SLOT_W      = 3;
    localparam int unsigned TERM_W      = 5;
    localparam int unsigned CNT_W       = 6;
    localparam int unsigned CODE_W      = 3;
    localparam int unsigned PROD_W      = RESULT_SIZE + WORD_SIZE;

    typedef enum logic [1:0] {
        MODE_GET_COMMAND = 2'd0,
        MODE_COMP        = 2'd1,
        MODE_OUTPUT      = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        OP_STP = 2'd0,
        OP_EVP = 2'd1,
        OP_EVB = 2'd2,
        OP_RST = 2'd3
    } opcode_e;

    typedef enum logic [CODE_W-1:0] {
        ST_OK    = 3'd0,
        ST_UNDEF = 3'd1,
        ST_OVF   = 3'd2
    } status_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [SLOT_W-1:0]  arg1;
        logic [TERM_W-1:0]  arg2;
    } cmd_t;

    function automatic logic [WORD_SIZE-1:0] status_word(input logic [INSTR_W-1:0] instr,
                                                         input status_e code);
        return {instr, 5'b0, code};
    endfunction

endpackage

// File: rtl/pea_horner_step.sv
// One Horner step: acc*x + coef, wrapped to RESULT_SIZE with a signed overflow flag.
module pea_horner_step
    import pea_pkg::*;
(
    input  logic [RESULT_SIZE-1:0] acc_i,
    input  logic [WORD_SIZE-1:0]   x_i,
    input  logic [WORD_SIZE-1:0]   coef_i,
    output logic [RESULT_SIZE-1:0] sum_o,
    output logic                   ovf_o
);

    logic signed [PROD_W-1:0] acc_ext;
    logic signed [PROD_W-1:0] x_ext;
    logic signed [PROD_W-1:0] coef_ext;
    logic signed [PROD_W-1:0] full;

    assign acc_ext  = {{(PROD_W-RESULT_SIZE){acc_i[RESULT_SIZE-1]}}, acc_i};
    assign x_ext    = {{(PROD_W-WORD_SIZE){x_i[WORD_SIZE-1]}}, x_i};
    assign coef_ext = {{(PROD_W-WORD_SIZE){coef_i[WORD_SIZE-1]}}, coef_i};

    // 32x16 signed product plus a 16-bit term always fits in 48 bits
    assign full  = acc_ext * x_ext + coef_ext;
    assign sum_o = full[RESULT_SIZE-1:0];
    assign ovf_o = full[PROD_W-1:RESULT_SIZE-1] != {(PROD_W-RESULT_SIZE+1){full[RESULT_SIZE-1]}};

endmodule

// File: rtl/pea_invoke.sv
// PEA firing engine: fetches a command, stores or evaluates polynomials, emits results and status.
module pea_invoke
    import pea_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   invoke,
    output logic [1:0]             mode_out,
    output logic                   busy,
    output logic                   done,
    input  logic [WORD_SIZE-1:0]   control_in,
    output logic                   control_rd_en,
    input  logic [WORD_SIZE-1:0]   data_in,
    output logic                   data_rd_en,
    output logic [RESULT_SIZE-1:0] result_out,
    output logic                   result_wr_en,
    input  logic                   result_full,
    output logic [WORD_SIZE-1:0]   status_out,
    output logic                   status_wr_en,
    input  logic                   status_full
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_STORE, S_POP, S_HORNER, S_DRAIN, S_OUT_RES, S_OUT_STAT
    } state_e;

    state_e                               state_q, state_d;
    mode_e                                mode_q, mode_d;
    logic                                 busy_q, busy_d, done_q, done_d;
    logic                                 ctrl_rd_q, ctrl_rd_d, data_rd_q, data_rd_d;
    logic                                 res_pend_q, res_pend_d, stat_pend_q, stat_pend_d;
    logic [RESULT_SIZE-1:0]               result_out_q, result_out_d;
    logic [WORD_SIZE-1:0]                 status_out_q, status_out_d;
    cmd_t                                 cmd_q, cmd_d;
    logic [NUM_SLOTS-1:0]                 valid_q, valid_d;
    logic [NUM_SLOTS-1:0][TERM_W-1:0]     degree_q, degree_d;
    logic [TERM_W-1:0]                    cnt_q, cnt_d, k_q, k_d;
    logic [RESULT_SIZE-1:0]               acc_q, acc_d;
    logic [WORD_SIZE-1:0]                 x_q, x_d;
    logic [CNT_W-1:0]                     res_cnt_q, res_cnt_d, rd_ptr_q, rd_ptr_d;
    logic                                 ovf_q, ovf_d, undef_q, undef_d;

    logic [WORD_SIZE-1:0]   coef_mem [NUM_SLOTS][MAX_TERMS];
    logic [RESULT_SIZE-1:0] res_buf  [MAX_TERMS];

    logic                   coef_we, buf_we;
    logic [RESULT_SIZE-1:0] buf_wdata;
    logic [TERM_W-1:0]      coef_idx, deg_sel, k_sel;
    logic [WORD_SIZE-1:0]   coef_rd;
    logic [RESULT_SIZE-1:0] coef_ext, step_sum;
    logic                   step_ovf;
    opcode_e                op;
    status_e                code;

    assign op       = opcode_e'(cmd_q.instr[1:0]);
    assign deg_sel  = degree_q[cmd_q.arg1];
    assign k_sel    = (op == OP_EVP) ? TERM_W'(1) : cmd_q.arg2;
    assign coef_idx = (state_q == S_HORNER) ? TERM_W'(cnt_q - TERM_W'(1)) : deg_sel;
    assign coef_rd  = coef_mem[cmd_q.arg1][coef_idx];
    assign coef_ext = {{(RESULT_SIZE-WORD_SIZE){coef_rd[WORD_SIZE-1]}}, coef_rd};
    assign code     = undef_q ? ST_UNDEF : (ovf_q ? ST_OVF : ST_OK);

    pea_horner_step u_step (
        .acc_i  (acc_q),
        .x_i    (x_q),
        .coef_i (coef_rd),
        .sum_o  (step_sum),
        .ovf_o  (step_ovf)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        ctrl_rd_d    = 1'b0;
        data_rd_d    = 1'b0;
        res_pend_d   = res_pend_q;
        stat_pend_d  = stat_pend_q;
        result_out_d = result_out_q;
        status_out_d = status_out_q;
        cmd_d        = cmd_q;
        valid_d      = valid_q;
        degree_d     = degree_q;
        cnt_d        = cnt_q;
        k_d          = k_q;
        acc_d        = acc_q;
        x_d          = x_q;
        res_cnt_d    = res_cnt_q;
        rd_ptr_d     = rd_ptr_q;
        ovf_d        = ovf_q;
        undef_d      = undef_q;
        coef_we      = 1'b0;
        buf_we       = 1'b0;
        buf_wdata    = step_sum;

        case (state_q)
            S_IDLE: begin
                if (invoke) begin
                    case (mode_q)
                        MODE_GET_COMMAND: begin
                            state_d   = S_CMD;
                            ctrl_rd_d = 1'b1;
                            busy_d    = 1'b1;
                        end
                        MODE_COMP: begin
                            if (op == OP_RST) begin
                                valid_d = '0;
                                done_d  = 1'b1;
                                mode_d  = MODE_OUTPUT;
                            end else if (op == OP_STP) begin
                                state_d   = S_STORE;
                                data_rd_d = 1'b1;
                                busy_d    = 1'b1;
                                cnt_d     = cmd_q.arg2;
                            end else begin
                                undef_d = ~valid_q[cmd_q.arg1];
                                if (k_sel == '0) begin
                                    done_d = 1'b1;
                                    mode_d = MODE_OUTPUT;
                                end else begin
                                    k_d       = k_sel;
                                    data_rd_d = 1'b1;
                                    busy_d    = 1'b1;
                                    state_d   = valid_q[cmd_q.arg1] ? S_POP : S_DRAIN;
                                end
                            end
                        end
                        MODE_OUTPUT: begin
                            busy_d = 1'b1;
                            if (res_cnt_q != '0) begin
                                state_d      = S_OUT_RES;
                                res_pend_d   = 1'b1;
                                result_out_d = res_buf[0];
                                rd_ptr_d     = CNT_W'(1);
                            end else begin
                                state_d      = S_OUT_STAT;
                                stat_pend_d  = 1'b1;
                                status_out_d = status_word(cmd_q.instr, code);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_CMD: begin
                cmd_d   = cmd_t'(control_in);
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                mode_d  = MODE_COMP;
            end
            S_STORE: begin
                coef_we = 1'b1;
                if (cnt_q == '0) begin
                    degree_d[cmd_q.arg1] = cmd_q.arg2;
                    valid_d[cmd_q.arg1]  = 1'b1;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    mode_d  = MODE_OUTPUT;
                end else begin
                    cnt_d     = cnt_q - TERM_W'(1);
                    data_rd_d = 1'b1;
                end
            end
            S_POP, S_HORNER: begin
                // A result is complete after the pop when degree is 0, else on the last Horner step
                if (state_q == S_POP) begin
                    x_d       = data_in;
                    acc_d     = coef_ext;
                    cnt_d     = deg_sel;
                    buf_wdata = coef_ext;
                    buf_we    = (deg_sel == '0);
                    state_d   = S_HORNER;
                end else begin
                    acc_d  = step_sum;
                    ovf_d  = ovf_q | step_ovf;
                    cnt_d  = cnt_q - TERM_W'(1);
                    buf_we = (cnt_q == TERM_W'(1));
                end
                if (buf_we) begin
                    res_cnt_d = res_cnt_q + CNT_W'(1);
                    if (k_q == TERM_W'(1)) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        mode_d  = MODE_OUTPUT;
                    end else begin
                        k_d       = k_q - TERM_W'(1);
                        data_rd_d = 1'b1;
                        state_d   = S_POP;
                    end
                end
            end
            S_DRAIN: begin
                if (k_q == TERM_W'(1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    mode_d  = MODE_OUTPUT;
                end else begin
                    k_d       = k_q - TERM_W'(1);
                    data_rd_d = 1'b1;
                end
            end
            S_OUT_RES: begin
                if (!result_full) begin
                    if (rd_ptr_q == res_cnt_q) begin
                        res_pend_d   = 1'b0;
                        result_out_d = '0;
                        stat_pend_d  = 1'b1;
                        status_out_d = status_word(cmd_q.instr, code);
                        state_d      = S_OUT_STAT;
                    end else begin
                        result_out_d = res_buf[rd_ptr_q[TERM_W-1:0]];
                        rd_ptr_d     = rd_ptr_q + CNT_W'(1);
                    end
                end
            end
            S_OUT_STAT: begin
                if (!status_full) begin
                    stat_pend_d  = 1'b0;
                    status_out_d = '0;
                    res_cnt_d    = '0;
                    rd_ptr_d     = '0;
                    ovf_d        = 1'b0;
                    undef_d      = 1'b0;
                    state_d      = S_IDLE;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    mode_d       = MODE_GET_COMMAND;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            mode_q       <= MODE_GET_COMMAND;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ctrl_rd_q    <= 1'b0;
            data_rd_q    <= 1'b0;
            res_pend_q   <= 1'b0;
            stat_pend_q  <= 1'b0;
            result_out_q <= '0;
            status_out_q <= '0;
            cmd_q        <= '0;
            valid_q      <= '0;
            degree_q     <= '0;
            cnt_q        <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            x_q          <= '0;
            res_cnt_q    <= '0;
            rd_ptr_q     <= '0;
            ovf_q        <= 1'b0;
            undef_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ctrl_rd_q    <= ctrl_rd_d;
            data_rd_q    <= data_rd_d;
            res_pend_q   <= res_pend_d;
            stat_pend_q  <= stat_pend_d;
            result_out_q <= result_out_d;
            status_out_q <= status_out_d;
            cmd_q        <= cmd_d;
            valid_q      <= valid_d;
            degree_q     <= degree_d;
            cnt_q        <= cnt_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            x_q          <= x_d;
            res_cnt_q    <= res_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            ovf_q        <= ovf_d;
            undef_q      <= undef_d;
        end
    end

    // Coefficient store and result buffer keep their contents across reset
    always_ff @(posedge clk) begin
        if (coef_we) coef_mem[cmd_q.arg1][cnt_q] <= data_in;
        if (buf_we)  res_buf[res_cnt_q[TERM_W-1:0]] <= buf_wdata;
    end

    assign mode_out      = mode_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign control_rd_en = ctrl_rd_q;
    assign data_rd_en    = data_rd_q;
    assign result_out    = result_out_q;
    assign status_out    = status_out_q;
    // FIFO pushes are gated by the full flags in the same cycle
    assign result_wr_en  = res_pend_q & ~result_full;
    assign status_wr_en  = stat_pend_q & ~status_full;

endmodule

// File: tb/tb_pea_invoke.sv
// Scoreboard bench for pea_invoke: FIFO models, a Horner reference model and cycle-count checks.
module tb_pea_invoke;

    logic        clk = 1'b0;
    logic        rst;
    logic        invoke;
    logic [1:0]  mode_out;
    logic        busy, done;
    logic [15:0] control_in;
    logic        control_rd_en;
    logic [15:0] data_in;
    logic        data_rd_en;
    logic [31:0] result_out;
    logic        result_wr_en;
    logic        result_full;
    logic [15:0] status_out;
    logic        status_wr_en;
    logic        status_full;

    always #5 clk = ~clk;

    pea_invoke dut (
        .clk           (clk),
        .rst           (rst),
        .invoke        (invoke),
        .mode_out      (mode_out),
        .busy          (busy),
        .done          (done),
        .control_in    (control_in),
        .control_rd_en (control_rd_en),
        .data_in       (data_in),
        .data_rd_en    (data_rd_en),
        .result_out    (result_out),
        .result_wr_en  (result_wr_en),
        .result_full   (result_full),
        .status_out    (status_out),
        .status_wr_en  (status_wr_en),
        .status_full   (status_full)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [15:0] ctrl_fifo[$];
    logic [15:0] data_fifo[$];
    logic [15:0] pend_d[$];
    logic [31:0] exp_res[$];
    logic [15:0] exp_stat[$];

    logic signed [15:0] m_coef [8][32];
    int                 m_deg  [8];
    bit                 m_valid[8];

    bit pop_c, pop_d;

    // Output monitor and pop capture
    always @(negedge clk) begin
        pop_c = control_rd_en;
        pop_d = data_rd_en;
        if (result_full) chk("res_wr_while_full", 32'(result_wr_en), 32'd0);
        if (result_wr_en) begin
            chk("res_expected", 32'(exp_res.size() != 0), 32'd1);
            if (exp_res.size() != 0) chk("result", result_out, exp_res.pop_front());
        end
        if (status_wr_en) begin
            chk("stat_expected", 32'(exp_stat.size() != 0), 32'd1);
            if (exp_stat.size() != 0) chk("status", 32'(status_out), 32'(exp_stat.pop_front()));
        end
    end

    // FWFT FIFO heads advance just after the edge that popped them
    always @(posedge clk) begin
        logic [15:0] tmp;
        #1;
        if (pop_c && ctrl_fifo.size() != 0) tmp = ctrl_fifo.pop_front();
        if (pop_d && data_fifo.size() != 0) tmp = data_fifo.pop_front();
        control_in = (ctrl_fifo.size() != 0) ? ctrl_fifo[0] : 16'h0;
        data_in    = (data_fifo.size() != 0) ? data_fifo[0] : 16'h0;
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 32'({mode_out, busy, done, control_rd_en, data_rd_en,
                                result_wr_en, status_wr_en}), 32'd0);
        chk({tag, "_result"}, result_out, 32'd0);
        chk({tag, "_status"}, 32'(status_out), 32'd0);
    endtask

    task automatic fire(input string tag, input logic [1:0] exp_mode, input int exp_cyc,
                        input bit bp, input bit poke);
        bit seen;
        int cyc;
        seen = 0;
        cyc  = 0;
        @(posedge clk); #1 invoke = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            invoke      = poke && (c == 2) && busy;
            result_full = bp && (c >= 2) && (c <= 4);
            @(negedge clk);
            if (done) begin
                seen = 1;
                cyc  = c;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_mode"}, 32'(mode_out), 32'(exp_mode));
            if (exp_cyc >= 0) chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
        end
    endtask

    // Reference model: updates slot state and queues expected tokens
    task automatic model_cmd(input logic [15:0] ctrl, output int n_res);
        logic [7:0] instr;
        int slot, a2, k;
        logic [2:0] code;
        bit ovf;
        longint acc, full, x;
        instr = ctrl[15:8];
        slot  = int'(ctrl[7:5]);
        a2    = int'(ctrl[4:0]);
        code  = 3'd0;
        ovf   = 0;
        n_res = 0;
        case (ctrl[9:8])
            2'd0: begin
                for (int i = 0; i <= a2; i++) m_coef[slot][a2 - i] = pend_d[i];
                m_deg[slot]   = a2;
                m_valid[slot] = 1;
            end
            2'd3: for (int s = 0; s < 8; s++) m_valid[s] = 0;
            default: begin
                k = (ctrl[9:8] == 2'd1) ? 1 : a2;
                if (!m_valid[slot]) code = 3'd1;
                else begin
                    for (int j = 0; j < k; j++) begin
                        x   = longint'($signed(pend_d[j]));
                        acc = longint'(m_coef[slot][m_deg[slot]]);
                        for (int i = m_deg[slot] - 1; i >= 0; i--) begin
                            full = acc * x + longint'(m_coef[slot][i]);
                            if (full > 64'sd2147483647 || full < -64'sd2147483648) ovf = 1;
                            acc = longint'($signed(full[31:0]));
                        end
                        exp_res.push_back(acc[31:0]);
                        n_res++;
                    end
                end
            end
        endcase
        if (code == 3'd0 && ovf) code = 3'd2;
        exp_stat.push_back({instr, 5'b0, code});
    endtask

    task automatic run_cmd(input logic [15:0] ctrl, input int comp_cyc, input bit bp);
        int n_res;
        ctrl_fifo.push_back(ctrl);
        foreach (pend_d[i]) data_fifo.push_back(pend_d[i]);
        model_cmd(ctrl, n_res);
        fire("gc", 2'd1, 2, 0, 0);
        chk("ctrl_consumed", 32'(ctrl_fifo.size()), 32'd0);
        fire("comp", 2'd2, comp_cyc, 0, 0);
        chk("data_consumed", 32'(data_fifo.size()), 32'd0);
        fire("out", 2'd0, n_res + 2 + (bp ? 3 : 0), bp, bp);
        pend_d.delete();
    endtask

    initial begin
        rst         = 1'b0;
        invoke      = 1'b0;
        result_full = 1'b0;
        status_full = 1'b0;
        pop_c       = 0;
        pop_d       = 0;
        for (int s = 0; s < 8; s++) begin
            m_valid[s] = 0;
            m_deg[s]   = 0;
        end
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst = 1'b1;

        // Store slot 4, then abort a second store mid-pop with reset
        pend_d = '{16'd1, 16'd1};
        run_cmd(16'h0081, -1, 0);
        ctrl_fifo.push_back(16'h0085);
        for (int i = 0; i < 6; i++) data_fifo.push_back(16'(i + 10));
        fire("abort_gc", 2'd1, 2, 0, 0);
        @(posedge clk); #1 invoke = 1'b1;
        @(posedge clk); #1 invoke = 1'b0;
        @(posedge clk); #1;
        chk("abort_popping", 32'(data_rd_en), 32'd1);
        rst = 1'b0;
        #1 check_reset_outputs("abort_async");
        @(negedge clk);
        check_reset_outputs("abort");
        data_fifo.delete();
        for (int s = 0; s < 8; s++) m_valid[s] = 0;
        @(posedge clk); #1 rst = 1'b1;

        pend_d = '{16'd9};
        run_cmd(16'h0180, 2, 0);

        pend_d = '{16'd3, 16'hFFFE, 16'd5};
        run_cmd(16'h0042, -1, 0);
        pend_d = '{16'd4};
        run_cmd(16'h0140, 4, 0);
        pend_d = '{16'd0, 16'd1, 16'hFFFF};
        run_cmd(16'h0243, 10, 1);
        pend_d = '{16'd7};
        run_cmd(16'h01A0, 2, 0);
        run_cmd(16'h0300, 1, 0);
        pend_d = '{16'd4};
        run_cmd(16'h0140, 2, 0);

        pend_d = '{16'd32767, 16'd0, 16'd0, 16'd0};
        run_cmd(16'h0003, -1, 0);
        pend_d = '{16'd32767};
        run_cmd(16'h0100, 5, 0);
        run_cmd(16'h0200, 1, 0);

        chk("res_queue_drained", 32'(exp_res.size()), 32'd0);
        chk("stat_queue_drained", 32'(exp_stat.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
